// File: rtl/fp_systolic_pe.sv
// fp_systolic_pe: FP32 multiply-accumulate element for an output-stationary
// systolic array. Three-stage MAC (operand latch, multiply, accumulate) plus
// a free-running FWD_LAT-deep forwarding path so elements tile by abutment.
`timescale 1ns/1ps
module fp_systolic_pe #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_TERMS = 1024,
  parameter int FWD_LAT   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] IN_TOP,
  input  logic [DATA_W-1:0] IN_LEFT,
  input  logic              IN_VALID,
  input  logic              IN_LAST,
  input  logic              ACC_CLEAR,
  output logic [DATA_W-1:0] OUT_RIGHT,
  output logic [DATA_W-1:0] OUT_BOTTOM,
  output logic              OUT_VALID,
  output logic              OUT_LAST,
  output logic [DATA_W-1:0] RESULT,
  output logic              RESULT_VALID,
  output logic [CNT_W-1:0]  TERM_CNT,
  output logic              ERR_OVF
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  // FP32 multiply, round-to-nearest-even; zero operands give +0, subnormals flush.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       p;
    logic [22:0]       m;
    logic              g, st;
    logic signed [10:0] e;
    logic [23:0]       mr;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 32'd0;
    if (a[30:23] == 8'hFF) return {s, 8'hFF, a[22:0]};
    if (b[30:23] == 8'hFF) return {s, 8'hFF, b[22:0]};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 11'sd1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
    mr = {1'b0, m} + {23'd0, g & (st | m[0])};
    if (mr[23]) e = e + 11'sd1;
    if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 11'sd0) return 32'd0;
    return {s, e[7:0], mr[22:0]};
  endfunction

  // FP32 add; a zero addend passes the other through, exact cancellation gives +0.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [26:0]       mx, my, lost_mask;
    logic [27:0]       sum;
    logic [7:0]        d;
    logic signed [9:0] e;
    logic [23:0]       mr;
    logic              sticky;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 32'd0;
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (b[30:0] > a[30:0]) begin x = b; y = a; end
    else begin x = a; y = b; end
    if (x[30:23] == 8'd0) return 32'd0;
    if (y[30:23] == 8'd0) return x;
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    if (d > 8'd26) begin
      // smaller addend lies entirely below the guard bits
      my = 27'd1;
    end else begin
      lost_mask = (27'd1 << d) - 27'd1;
      sticky    = |(my & lost_mask);
      my        = (my >> d) | {26'd0, sticky};
    end
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, my};
    else                sum = {1'b0, mx} - {1'b0, my};
    if (sum == 28'd0) return 32'd0;
    e = $signed({2'b00, x[30:23]});
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 10'sd1;
        end
      end
    end
    mr = {1'b0, sum[25:3]} + {23'd0, sum[2] & ((|sum[1:0]) | sum[3])};
    if (mr[23]) e = e + 10'sd1;
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 10'sd0) return 32'd0;
    return {x[31], e[7:0], mr[22:0]};
  endfunction

  logic [31:0] reg_top, reg_left, pipe, acc, result_q, mul_q, sum_q;
  logic [2:1]  vld_pipe, lst_pipe;
  logic        first, result_valid_q, err_ovf_q;
  logic [CNT_W-1:0] term_cnt;

  logic [FWD_LAT-1:0][DATA_W-1:0] fwd_right, fwd_bottom;
  logic [FWD_LAT-1:0]             fwd_valid, fwd_last;

  // Arithmetic for S2 (product) and S3 (running sum).
  always_comb begin
    mul_q = fp_mul(reg_top, reg_left);
    sum_q = first ? pipe : fp_add(acc, pipe);
  end

  // S1: operand latch; a clear also kills the term arriving this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reg_top     <= '0;
      reg_left    <= '0;
      vld_pipe[1] <= 1'b0;
      lst_pipe[1] <= 1'b0;
    end else begin
      reg_top     <= IN_TOP;
      reg_left    <= IN_LEFT;
      vld_pipe[1] <= IN_VALID & ~ACC_CLEAR;
      lst_pipe[1] <= IN_LAST & IN_VALID;
    end
  end

  // S2: multiply; bubbles leave PIPE untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe        <= '0;
      vld_pipe[2] <= 1'b0;
      lst_pipe[2] <= 1'b0;
    end else if (ACC_CLEAR) begin
      vld_pipe[2] <= 1'b0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        pipe        <= mul_q;
        lst_pipe[2] <= lst_pipe[1];
      end
    end
  end

  // S3: accumulate, publish on LAST, count terms and flag overruns.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc            <= '0;
      first          <= 1'b1;
      term_cnt       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_ovf_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (ACC_CLEAR) begin
        acc      <= '0;
        first    <= 1'b1;
        term_cnt <= '0;
      end else if (vld_pipe[2]) begin
        if (lst_pipe[2]) begin
          result_q       <= sum_q;
          result_valid_q <= 1'b1;
          acc            <= '0;
          first          <= 1'b1;
          term_cnt       <= '0;
        end else begin
          acc   <= sum_q;
          first <= 1'b0;
          if (term_cnt < MAX_CNT) term_cnt <= term_cnt + 1'b1;
          if (term_cnt >= MAX_CNT - 1'b1) err_ovf_q <= 1'b1;
        end
      end
    end
  end

  // Forwarding shift registers: always shifting, blind to ACC_CLEAR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fwd_right  <= '0;
      fwd_bottom <= '0;
      fwd_valid  <= '0;
      fwd_last   <= '0;
    end else begin
      fwd_right[0]  <= IN_LEFT;
      fwd_bottom[0] <= IN_TOP;
      fwd_valid[0]  <= IN_VALID;
      fwd_last[0]   <= IN_LAST;
      for (int i = 1; i < FWD_LAT; i++) begin
        fwd_right[i]  <= fwd_right[i-1];
        fwd_bottom[i] <= fwd_bottom[i-1];
        fwd_valid[i]  <= fwd_valid[i-1];
        fwd_last[i]   <= fwd_last[i-1];
      end
    end
  end

  assign OUT_RIGHT    = fwd_right[FWD_LAT-1];
  assign OUT_BOTTOM   = fwd_bottom[FWD_LAT-1];
  assign OUT_VALID    = fwd_valid[FWD_LAT-1];
  assign OUT_LAST     = fwd_last[FWD_LAT-1];
  assign RESULT       = result_q;
  assign RESULT_VALID = result_valid_q;
  assign TERM_CNT     = term_cnt;
  assign ERR_OVF      = err_ovf_q;

endmodule

// File: tb/tb_fp_systolic_pe.sv
// Directed bench for fp_systolic_pe (MAX_TERMS=4, FWD_LAT=2).
`timescale 1ns/1ps
module tb_fp_systolic_pe;

  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F5  = 32'h40A00000;
  localparam logic [31:0] FN2 = 32'hC0000000;
  localparam logic [31:0] NZ  = 32'h80000000;

  logic        CLK, RST_N;
  logic [31:0] IN_TOP, IN_LEFT;
  logic        IN_VALID, IN_LAST, ACC_CLEAR;
  logic [31:0] OUT_RIGHT, OUT_BOTTOM, RESULT;
  logic        OUT_VALID, OUT_LAST, RESULT_VALID, ERR_OVF;
  logic [15:0] TERM_CNT;

  int n_checks, n_err;

  fp_systolic_pe #(.DATA_W(32), .CNT_W(16), .MAX_TERMS(4), .FWD_LAT(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_TOP(IN_TOP), .IN_LEFT(IN_LEFT),
    .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .ACC_CLEAR(ACC_CLEAR),
    .OUT_RIGHT(OUT_RIGHT), .OUT_BOTTOM(OUT_BOTTOM), .OUT_VALID(OUT_VALID),
    .OUT_LAST(OUT_LAST), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID),
    .TERM_CNT(TERM_CNT), .ERR_OVF(ERR_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] t, input logic [31:0] l, input logic v, input logic la);
    IN_TOP = t; IN_LEFT = l; IN_VALID = v; IN_LAST = la;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    RST_N = 1'b0; ACC_CLEAR = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_result", RESULT, 32'd0);
    chk("rst_rv", 32'(RESULT_VALID), 32'd0);
    chk("rst_cnt", 32'(TERM_CNT), 32'd0);
    chk("rst_err", 32'(ERR_OVF), 32'd0);
    chk("rst_right", OUT_RIGHT, 32'd0);
    chk("rst_oval", 32'(OUT_VALID), 32'd0);
    RST_N = 1'b1;
    tick();

    // single term 2*3
    drive(F2, F3, 1'b1, 1'b1); tick();
    idle(); tick();
    chk("t1_early", 32'(RESULT_VALID), 32'd0);
    tick();
    chk("t1_rv", 32'(RESULT_VALID), 32'd1);
    chk("t1_res", RESULT, 32'h40C00000);
    chk("t1_cnt", 32'(TERM_CNT), 32'd0);
    tick();
    chk("t1_pulse_end", 32'(RESULT_VALID), 32'd0);
    chk("t1_hold", RESULT, 32'h40C00000);

    // dot [1,2]x[3,4] back to back
    drive(F1, F3, 1'b1, 1'b0); tick();
    drive(F2, F4, 1'b1, 1'b1); tick();
    idle(); tick();
    chk("t2_cnt_mid", 32'(TERM_CNT), 32'd1);
    chk("t2_rv_early", 32'(RESULT_VALID), 32'd0);
    tick();
    chk("t2_rv", 32'(RESULT_VALID), 32'd1);
    chk("t2_res", RESULT, 32'h41300000);
    chk("t2_cnt_end", 32'(TERM_CNT), 32'd0);

    // same dot with an idle gap
    drive(F1, F3, 1'b1, 1'b0); tick();
    idle(); tick();
    drive(F2, F4, 1'b1, 1'b1); tick();
    idle(); tick();
    chk("t2g_rv_early", 32'(RESULT_VALID), 32'd0);
    tick();
    chk("t2g_rv", 32'(RESULT_VALID), 32'd1);
    chk("t2g_res", RESULT, 32'h41300000);

    // cancellation 6 + (-6)
    drive(F2, F3, 1'b1, 1'b0); tick();
    drive(FN2, F3, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    chk("t3a_rv", 32'(RESULT_VALID), 32'd1);
    chk("t3a_res", RESULT, 32'h00000000);

    // -0*5 then 2*2
    drive(NZ, F5, 1'b1, 1'b0); tick();
    drive(F2, F2, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    chk("t3b_rv", 32'(RESULT_VALID), 32'd1);
    chk("t3b_res", RESULT, 32'h40800000);

    // back-to-back dot products
    drive(F1, F3, 1'b1, 1'b1); tick();
    drive(F2, F4, 1'b1, 1'b1); tick();
    idle(); tick();
    chk("t4_rv0", 32'(RESULT_VALID), 32'd1);
    chk("t4_res0", RESULT, 32'h40400000);
    tick();
    chk("t4_rv1", 32'(RESULT_VALID), 32'd1);
    chk("t4_res1", RESULT, 32'h41000000);
    tick();
    chk("t4_rv_end", 32'(RESULT_VALID), 32'd0);

    // ACC_CLEAR while LAST sits in S3, plus a term presented during the clear
    drive(F1, F1, 1'b1, 1'b0); tick();
    drive(F1, F1, 1'b1, 1'b0); tick();
    drive(F1, F1, 1'b1, 1'b1); tick();
    idle(); tick();
    chk("t5_cnt_pre", 32'(TERM_CNT), 32'd2);
    ACC_CLEAR = 1'b1;
    drive(F5, F5, 1'b1, 1'b0); tick();
    ACC_CLEAR = 1'b0;
    chk("t5_rv", 32'(RESULT_VALID), 32'd0);
    chk("t5_res_hold", RESULT, 32'h41000000);
    chk("t5_cnt_clr", 32'(TERM_CNT), 32'd0);
    drive(F1, F1, 1'b1, 1'b1); tick();
    idle(); tick();
    chk("t5_cnt_after", 32'(TERM_CNT), 32'd0);
    tick();
    chk("t5b_rv", 32'(RESULT_VALID), 32'd1);
    chk("t5b_res", RESULT, 32'h3F800000);

    // overflow: five non-last terms with MAX_TERMS=4
    repeat (5) begin
      drive(F1, F1, 1'b1, 1'b0); tick();
    end
    idle();
    chk("t6_cnt3", 32'(TERM_CNT), 32'd3);
    chk("t6_err_pre", 32'(ERR_OVF), 32'd0);
    tick();
    chk("t6_cnt4", 32'(TERM_CNT), 32'd4);
    chk("t6_err_set", 32'(ERR_OVF), 32'd1);
    tick();
    chk("t6_cnt_sat", 32'(TERM_CNT), 32'd4);
    drive(F1, F1, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    chk("t6_rv", 32'(RESULT_VALID), 32'd1);
    chk("t6_res", RESULT, 32'h40C00000);
    chk("t6_cnt_end", 32'(TERM_CNT), 32'd0);
    chk("t6_err_sticky", 32'(ERR_OVF), 32'd1);
    tick();

    // forwarding, FWD_LAT=2; raw LAST without VALID
    drive(32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1); tick();
    idle();
    chk("fwd_not_yet", OUT_RIGHT, 32'd0);
    tick();
    chk("fwd_right", OUT_RIGHT, 32'hDEADBEEF);
    chk("fwd_bottom", OUT_BOTTOM, 32'h12345678);
    chk("fwd_oval", 32'(OUT_VALID), 32'd0);
    chk("fwd_olast", 32'(OUT_LAST), 32'd1);
    tick();
    chk("fwd_olast_end", 32'(OUT_LAST), 32'd0);
    chk("fwd_no_rv", 32'(RESULT_VALID), 32'd0);
    // forwarding ignores ACC_CLEAR, the MAC does not
    ACC_CLEAR = 1'b1;
    drive(F3, F4, 1'b1, 1'b1); tick();
    ACC_CLEAR = 1'b0;
    idle(); tick();
    chk("fwd_clr_oval", 32'(OUT_VALID), 32'd1);
    chk("fwd_clr_right", OUT_RIGHT, F4);
    chk("fwd_clr_olast", 32'(OUT_LAST), 32'd1);
    tick(); tick();
    chk("fwd_clr_no_rv", 32'(RESULT_VALID), 32'd0);
    chk("fwd_clr_res", RESULT, 32'h40C00000);

    // async reset mid-stream
    repeat (3) begin
      drive(F1, F1, 1'b1, 1'b0); tick();
    end
    chk("ar_cnt_pre", 32'(TERM_CNT), 32'd1);
    #3 RST_N = 1'b0;
    #1;
    chk("ar_result", RESULT, 32'd0);
    chk("ar_cnt", 32'(TERM_CNT), 32'd0);
    chk("ar_err", 32'(ERR_OVF), 32'd0);
    chk("ar_right", OUT_RIGHT, 32'd0);
    chk("ar_oval", 32'(OUT_VALID), 32'd0);
    chk("ar_rv", 32'(RESULT_VALID), 32'd0);
    tick();
    RST_N = 1'b1;
    idle();
    tick(); tick(); tick();
    chk("ar_post_rv", 32'(RESULT_VALID), 32'd0);
    chk("ar_post_cnt", 32'(TERM_CNT), 32'd0);
    drive(F2, F2, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    chk("ar_fresh_rv", 32'(RESULT_VALID), 32'd1);
    chk("ar_fresh_res", RESULT, 32'h40800000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
